// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 16;
    localparam int MULT_CNT_W = 4;
    localparam int MULT_HI_W  = MULT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    typedef enum logic [2:0] {
        B_ZERO,
        B_PM,
        B_P2M,
        B_NM,
        B_N2M
    } booth_op_t;

    // Radix-4 Booth digit for the window {q[i+1], q[i], q[i-1]}.
    function automatic booth_op_t booth_decode(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = B_PM;
            3'b011:         op = B_P2M;
            3'b100:         op = B_N2M;
            3'b101, 3'b110: op = B_NM;
            default:        op = B_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_recode4.sv
// Combinational radix-4 Booth recoder: selects 0, +-Mx or +-2Mx as the addend.
module booth_recode4
    import mult_pkg::*;
(
    input  logic [2:0]           bits,
    input  logic [MULT_HI_W-1:0] mx,
    output logic [MULT_HI_W-1:0] addend
);

    booth_op_t             op;
    logic [MULT_HI_W-1:0]  mx2;

    assign op  = booth_decode(bits);
    assign mx2 = {mx[MULT_HI_W-2:0], 1'b0};

    // NOTE: every case arm assigns addend and a default covers the rest, so no latch is inferred.
    always_comb begin
        addend = '0;
        case (op)
            B_PM:    addend = mx;
            B_P2M:   addend = mx2;
            B_NM:    addend = -mx;
            B_N2M:   addend = -mx2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_iter.sv
// Sequential signed 32x32 radix-4 Booth multiplier, 16 iterations per product.
// Optional overflow flag enabled by defining MULT_OVF_EN.
module booth_mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITERS = MULT_ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    mult_state_t           state, state_next;
    logic [MULT_CNT_W-1:0] cnt;
    logic [WIDTH+1:0]      hi, mx;
    logic [WIDTH-1:0]      lo;
    logic                  qm1;

    logic [WIDTH+1:0]      addend, sum, hi_step;
    logic [WIDTH-1:0]      lo_step;
    logic                  qm1_step;
    logic                  start, last_step;

    assign start     = ctrl_MULT && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (cnt == MULT_CNT_W'(ITERS - 1));

    booth_recode4 u_recode (
        .bits   ({lo[1:0], qm1}),
        .mx     (mx),
        .addend (addend)
    );

    // One step: add to hi modulo 2^34, then arithmetic-shift {hi, lo, qm1} right by two.
    assign sum      = hi + addend;
    assign hi_step  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    assign lo_step  = {sum[1:0], lo[WIDTH-1:2]};
    assign qm1_step = lo[1];

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state == RUN);
        data_resultRDY = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            qm1         <= 1'b0;
            mx          <= '0;
            cnt         <= '0;
            data_result <= '0;
        end else if (start) begin
            hi  <= '0;
            lo  <= data_operandB;
            qm1 <= 1'b0;
            mx  <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            cnt <= '0;
        end else if (state == RUN) begin
            hi  <= hi_step;
            lo  <= lo_step;
            qm1 <= qm1_step;
            cnt <= cnt + 1'b1;
            if (last_step) data_result <= lo_step;
        end
    end

`ifdef MULT_OVF_EN
    // Product bits [63:31] must all match the sign for the low word to be exact.
    logic [WIDTH:0] prod_top;
    logic           ovf_next;
    logic           exc_q;

    assign prod_top = {hi_step[WIDTH-1:0], lo_step[WIDTH-1]};
    assign ovf_next = !((&prod_top) || !(|prod_top));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          exc_q <= 1'b0;
        else if (last_step) exc_q <= ovf_next;
    end

    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_iter.sv
// Scoreboard bench for booth_mult_iter: driver pushes expected results, monitor checks on RDY.
module tb_booth_mult_iter;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

`ifdef MULT_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    booth_mult_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && data_resultRDY) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rdy", 64'(data_resultRDY), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("result",      64'(data_result),    64'(e.res));
                    check("exception",   64'(data_exception), 64'(e.exc));
                    check("latency",     64'(cyc - e.start),  64'd16);
                    check("busy_at_rdy", 64'(busy),           64'd0);
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clock);
        if (sbq.size() != 0) begin
            check("timeout_pending", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        sbq.push_back('{res: res, exc: exc, start: cyc});
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("busy_in_run", 64'(busy), 64'd1);
        wait_drain();
        @(negedge clock);
        check("rdy_one_cycle", 64'(data_resultRDY), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
        $fatal(1);
    end

    initial begin
        int s;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst_result", 64'(data_result),    64'd0);
        check("rst_exc",    64'(data_exception), 64'd0);
        check("rst_rdy",    64'(data_resultRDY), 64'd0);
        check("rst_busy",   64'(busy),           64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        do_mult(32'd3,          32'd5,          32'h0000000F, 1'b0);
        do_mult(32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
        do_mult(32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, OVF);
        do_mult(32'h80000000,   32'hFFFFFFFF,   32'h80000000, OVF);

        // Abort 9*9 with reset in the 8th RUN cycle; no RDY may follow.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (7) @(negedge clock);
        check("pre_abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_result", 64'(data_result),    64'd0);
        check("abort_exc",    64'(data_exception), 64'd0);
        check("abort_rdy",    64'(data_resultRDY), 64'd0);
        check("abort_busy",   64'(busy),           64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("post_abort_busy", 64'(busy), 64'd0);
        do_mult(32'd2, 32'd2, 32'd4, 1'b0);

        // Start held high during RUN with other operands, then a start in the DONE cycle.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd6;
        @(posedge clock);
        #1;
        s = cyc;
        sbq.push_back('{res: 32'd18, exc: 1'b0, start: s});
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        repeat (10) @(negedge clock);
        ctrl_MULT = 1'b0;
        while (cyc < s + 16) @(negedge clock);
        check("done_cycle_rdy", 64'(data_resultRDY), 64'd1);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'hFFFFFFFF;
        data_operandB = 32'hFFFFFFFF;
        @(posedge clock);
        #1;
        sbq.push_back('{res: 32'd1, exc: 1'b0, start: cyc});
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_drain();
        repeat (3) @(negedge clock);
        check("final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
